// File: rtl/cnt_pkg.sv
// ---------------------------------------------------------------------------
// cnt_pkg
// Shared definitions for the modulo-N cascade counter family.
//   cnt_dir_e   : count direction (CNT_DOWN / CNT_UP)
//   next_digit  : one-digit step with wrap, in STEP_W bits so that a digit
//                 with MODULUS = 2^DW never overflows while stepping
//   clamp_digit : pins an out-of-range load value to MODULUS-1
// ---------------------------------------------------------------------------
package cnt_pkg;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_e;

    // Largest supported digit modulus and chain length.
    localparam int MAX_MODULUS = 256;
    localparam int MAX_DIGITS  = 8;

    // One bit wider than the widest digit (DW = 8 for MODULUS = 256).
    localparam int STEP_W = 9;

    // Next value of a single digit in the given direction. The last legal
    // value wraps to zero going up; zero wraps to the last legal value going
    // down.
    function automatic logic [STEP_W-1:0] next_digit(
        input logic [STEP_W-1:0] value,
        input cnt_dir_e          dir,
        input int unsigned       modulus
    );
        logic [STEP_W-1:0] last;
        last = STEP_W'(modulus - 1);
        if (dir == CNT_UP) begin
            next_digit = (value == last) ? '0 : value + STEP_W'(1);
        end else begin
            next_digit = (value == '0) ? last : value - STEP_W'(1);
        end
    endfunction

    // Load values that do not fit the modulus are clamped to its top value.
    function automatic logic [STEP_W-1:0] clamp_digit(
        input logic [STEP_W-1:0] value,
        input int unsigned       modulus
    );
        if (32'(value) >= modulus) begin
            clamp_digit = STEP_W'(modulus - 1);
        end else begin
            clamp_digit = value;
        end
    endfunction

endpackage

// File: rtl/mod_n_digit.sv
// ---------------------------------------------------------------------------
// mod_n_digit
// One digit of the cascade counter: a DW-bit register counting 0..MODULUS-1.
//   CLK         : clock, state changes on posedge
//   MR          : asynchronous active-high master reset, clears the digit
//   step        : advance one position in direction 'dir' this edge
//   dir         : CNT_UP / CNT_DOWN
//   load        : take loadValue (clamped) this edge, overrides step
//   loadValue   : raw parallel load value, may be out of range
//   q           : current digit value
//   atTerminal  : digit sits at the value that makes it roll over next step
//   loadClamped : loadValue is out of range and would be clamped
// ---------------------------------------------------------------------------
module mod_n_digit
    import cnt_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int DW      = $clog2(MODULUS)
) (
    input  logic          CLK,
    input  logic          MR,
    input  logic          step,
    input  cnt_dir_e      dir,
    input  logic          load,
    input  logic [DW-1:0] loadValue,
    output logic [DW-1:0] q,
    output logic          atTerminal,
    output logic          loadClamped
);

    localparam logic [STEP_W-1:0] LAST = STEP_W'(MODULUS - 1);

    logic [STEP_W-1:0] loadWide;
    logic [STEP_W-1:0] clampedWide;

    // The load value is widened before comparison so the range check is
    // done with the same arithmetic as stepping.
    assign loadWide    = STEP_W'(loadValue);
    assign clampedWide = clamp_digit(loadWide, MODULUS);
    assign loadClamped = (clampedWide != loadWide);

    // The terminal value depends on the direction currently requested, so
    // the carry chain and TC follow Up without waiting for a clock.
    assign atTerminal = (dir == CNT_UP) ? (STEP_W'(q) == LAST) : (q == '0);

    // Digit register: reset clears it at once, a load always wins over a
    // step, and a step uses the wrapping next_digit helper. A clamped load
    // can only ever produce MODULUS-1, so q stays in range by construction.
    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            q <= '0;
        end else if (load) begin
            q <= DW'(clampedWide);
        end else if (step) begin
            q <= DW'(next_digit(STEP_W'(q), dir, MODULUS));
        end
    end

    // Sanity checks on the digit value: never out of range, and always
    // zero while the master reset is held.
    always @(posedge CLK) begin
        assert (STEP_W'(q) <= LAST);
        if (MR) begin
            assert (q == '0);
        end
    end

endmodule

// File: rtl/mod_n_cascade_counter.sv
// ---------------------------------------------------------------------------
// mod_n_cascade_counter
// DIGITS cascaded modulo-MODULUS digits with up/down counting, clamped
// parallel load, terminal count and a whole-chain wrap pulse.
//   CLK     : clock, all state changes on posedge except reset
//   MR      : asynchronous active-high master reset
//   Load    : synchronous parallel load of P (beats Enable)
//   Enable  : count enable
//   Up      : 1 = increment, 0 = decrement, sampled at each edge
//   P       : load value, digit i at P[i*DW +: DW], digit 0 least significant
//   Q       : current count, same packing as P
//   TC      : combinational terminal count for the current direction
//   Ovf     : one-cycle pulse in the cycle after the whole chain wraps
//   LoadErr : one-cycle pulse after a load that had a clamped digit
// ---------------------------------------------------------------------------
module mod_n_cascade_counter
    import cnt_pkg::*;
#(
    parameter  int MODULUS = 10,
    parameter  int DIGITS  = 4,
    localparam int DW      = $clog2(MODULUS)
) (
    input  logic                 CLK,
    input  logic                 MR,
    input  logic                 Load,
    input  logic                 Enable,
    input  logic                 Up,
    input  logic [DIGITS*DW-1:0] P,
    output logic [DIGITS*DW-1:0] Q,
    output logic                 TC,
    output logic                 Ovf,
    output logic                 LoadErr
);

    cnt_dir_e          dir;
    logic              countEn;
    logic [DIGITS:0]   carry;
    logic [DIGITS-1:0] atTerm;
    logic [DIGITS-1:0] clamped;

    assign dir     = Up ? CNT_UP : CNT_DOWN;
    assign countEn = Enable & ~Load;

    // carry[i] is high when every digit below i sits at its terminal value,
    // i.e. digit i is due to step on this count. Digit 0 always steps.
    assign carry[0] = 1'b1;

    // One digit per position; each digit's step is the count enable gated
    // by the carry from all lower digits.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign carry[i+1] = carry[i] & atTerm[i];

        mod_n_digit #(
            .MODULUS (MODULUS),
            .DW      (DW)
        ) u_digit (
            .CLK         (CLK),
            .MR          (MR),
            .step        (countEn & carry[i]),
            .dir         (dir),
            .load        (Load),
            .loadValue   (P[i*DW +: DW]),
            .q           (Q[i*DW +: DW]),
            .atTerminal  (atTerm[i]),
            .loadClamped (clamped[i])
        );
    end

    // The whole chain is about to wrap when every digit is terminal and
    // counting is enabled. Load is deliberately not part of TC; it only
    // suppresses the registered Ovf pulse.
    assign TC = ~MR & Enable & carry[DIGITS];

    // Status flops: Ovf marks the cycle after a real wrap, LoadErr the cycle
    // after a load that had to clamp. Both drop the instant MR rises.
    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            Ovf     <= 1'b0;
            LoadErr <= 1'b0;
        end else begin
            Ovf     <= TC & ~Load;
            LoadErr <= Load & (|clamped);
        end
    end

endmodule

// File: tb/tb_mod_n_cascade_counter.sv
// ---------------------------------------------------------------------------
// tb_mod_n_cascade_counter
// Directed and randomised checks of the cascade counter. The main instance is
// the 4-digit BCD default; two extra instances cover MODULUS=16/DIGITS=2 and
// MODULUS=6/DIGITS=1. The reference model treats the counter as a single
// integer modulo MODULUS^DIGITS.
// ---------------------------------------------------------------------------
module tb_mod_n_cascade_counter;

    localparam int NA = 10000;

    logic        CLK = 1'b0;
    logic        MR, Load, Enable, Up;
    logic [15:0] P, Q;
    logic        TC, Ovf, LoadErr;

    logic        mrB, enB, upB, loadB;
    logic [7:0]  pB, qB;
    logic        tcB, ovfB, errB;

    logic        mrC, enC, upC, loadC;
    logic [2:0]  pC, qC;
    logic        tcC, ovfC, errC;

    int total = 0;
    int bad   = 0;
    int modelVal = 0;
    bit modelOvf = 1'b0;
    bit modelErr = 1'b0;
    int modelB, modelC;
    bit expOvfB, expOvfC;

    always #5 CLK = ~CLK;

    mod_n_cascade_counter #(.MODULUS(10), .DIGITS(4)) dutA (
        .CLK(CLK), .MR(MR), .Load(Load), .Enable(Enable), .Up(Up),
        .P(P), .Q(Q), .TC(TC), .Ovf(Ovf), .LoadErr(LoadErr)
    );

    mod_n_cascade_counter #(.MODULUS(16), .DIGITS(2)) dutB (
        .CLK(CLK), .MR(mrB), .Load(loadB), .Enable(enB), .Up(upB),
        .P(pB), .Q(qB), .TC(tcB), .Ovf(ovfB), .LoadErr(errB)
    );

    mod_n_cascade_counter #(.MODULUS(6), .DIGITS(1)) dutC (
        .CLK(CLK), .MR(mrC), .Load(loadC), .Enable(enC), .Up(upC),
        .P(pC), .Q(qC), .TC(tcC), .Ovf(ovfC), .LoadErr(errC)
    );

    // Decimal integer to four packed BCD nibbles.
    function automatic logic [15:0] packBcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Random legal BCD value.
    function automatic logic [15:0] randomBcd();
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic checkOutput(input string tag);
        expectEq({tag, ".Q"}, 32'(Q), 32'(packBcd(modelVal)));
        expectEq({tag, ".Ovf"}, 32'(Ovf), 32'(modelOvf));
        expectEq({tag, ".LoadErr"}, 32'(LoadErr), 32'(modelErr));
    endtask

    // One clock of the main instance: drive controls, check TC before the
    // edge, advance the model, check registered outputs after the edge.
    task automatic applyStimulus(input bit ld, input bit en, input bit up,
                                 input logic [15:0] p, input string tag);
        int v, mul, d;
        Load = ld; Enable = en; Up = up; P = p;
        #1;
        expectEq({tag, ".TC"}, 32'(TC),
                 32'(en && (up ? (modelVal == NA - 1) : (modelVal == 0))));
        @(posedge CLK);
        #1;
        if (ld) begin
            v = 0; mul = 1; modelErr = 1'b0;
            for (int i = 0; i < 4; i++) begin
                d = int'(p[i*4 +: 4]);
                if (d > 9) begin
                    d = 9;
                    modelErr = 1'b1;
                end
                v = v + d * mul;
                mul = mul * 10;
            end
            modelVal = v;
            modelOvf = 1'b0;
        end else if (en) begin
            modelOvf = up ? (modelVal == NA - 1) : (modelVal == 0);
            modelVal = up ? (modelVal + 1) % NA : (modelVal + NA - 1) % NA;
            modelErr = 1'b0;
        end else begin
            modelOvf = 1'b0;
            modelErr = 1'b0;
        end
        checkOutput(tag);
    endtask

    // Raise MR 2 units after the sampling point (3 after the posedge), check
    // the outputs cleared with no clock, release MR well before the next edge.
    task automatic pulseReset(input string tag);
        #2;
        Load = 1'b0; Enable = 1'b1; Up = 1'b0;
        MR = 1'b1;
        #1;
        modelVal = 0; modelOvf = 1'b0; modelErr = 1'b0;
        checkOutput(tag);
        expectEq({tag, ".TC"}, 32'(TC), 32'(0));
        #2;
        MR = 1'b0;
    endtask

    initial begin
        int sel;
        logic [15:0] pv;

        MR = 1'b1; Load = 1'b0; Enable = 1'b1; Up = 1'b0; P = '0;
        mrB = 1'b1; enB = 1'b0; upB = 1'b1; loadB = 1'b0; pB = '0;
        mrC = 1'b1; enC = 1'b0; upC = 1'b1; loadC = 1'b0; pC = '0;

        $display("[TB] reset state");
        @(posedge CLK);
        #1;
        checkOutput("reset");
        expectEq("reset.TC", 32'(TC), 32'(0));
        #2;
        MR = 1'b0;

        $display("[TB] asynchronous reset while counting");
        applyStimulus(1, 0, 1, 16'h0122, "ld0122");
        applyStimulus(0, 1, 1, 16'h0000, "cnt0123");
        pulseReset("asyncRst");
        applyStimulus(0, 1, 1, 16'h0000, "rel0001");

        $display("[TB] up cascade");
        applyStimulus(1, 0, 1, 16'h0998, "ld0998");
        applyStimulus(0, 1, 1, 16'h0000, "up0999");
        applyStimulus(0, 1, 1, 16'h0000, "up1000");
        applyStimulus(1, 0, 1, 16'h9999, "ld9999");
        applyStimulus(0, 1, 1, 16'h0000, "upWrap");
        applyStimulus(0, 1, 1, 16'h0000, "upAfterWrap");
        applyStimulus(1, 0, 1, 16'h9999, "ld9999b");
        applyStimulus(0, 1, 1, 16'h0000, "upWrapB");
        pulseReset("ovfDrop");
        applyStimulus(0, 1, 1, 16'h0000, "rel0001b");

        $display("[TB] down cascade and direction toggling");
        applyStimulus(1, 0, 0, 16'h1000, "ld1000");
        applyStimulus(0, 1, 0, 16'h0000, "dn0999");
        applyStimulus(1, 0, 0, 16'h0000, "ld0000");
        applyStimulus(0, 1, 0, 16'h0000, "dnWrap");
        applyStimulus(0, 1, 0, 16'h0000, "dnAfterWrap");
        applyStimulus(1, 0, 1, 16'h0500, "ld0500");
        applyStimulus(0, 1, 1, 16'h0000, "tgl0501");
        applyStimulus(0, 1, 0, 16'h0000, "tgl0500");
        applyStimulus(0, 1, 1, 16'h0000, "tgl0501b");

        $display("[TB] load clamping");
        applyStimulus(1, 0, 1, 16'hF3A2, "ldF3A2");
        applyStimulus(0, 0, 1, 16'h0000, "holdErr");
        applyStimulus(1, 0, 1, 16'h1234, "ld1234");

        $display("[TB] priority and hold");
        applyStimulus(1, 0, 1, 16'h0005, "ld0005");
        applyStimulus(1, 1, 1, 16'h0042, "ldBeatsEn");
        applyStimulus(1, 0, 1, 16'h9999, "ld9999c");
        applyStimulus(1, 1, 1, 16'h0042, "ldAtTc");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 1, 16'h0000, "hold");
        end

        $display("[TB] randomised traffic");
        for (int k = 0; k < 400; k++) begin
            sel = int'($urandom_range(0, 15));
            if (sel == 0) begin
                pulseReset("rndRst");
            end else if (sel < 3) begin
                applyStimulus(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              16'($urandom), "rndLdRaw");
            end else if (sel < 5) begin
                case ($urandom_range(0, 3))
                    0: pv = 16'h9999;
                    1: pv = 16'h0000;
                    2: pv = 16'h0999;
                    default: pv = randomBcd();
                endcase
                applyStimulus(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              pv, "rndLdBcd");
            end else begin
                applyStimulus(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                              16'($urandom), "rndCnt");
            end
        end

        $display("[TB] other parametrisations");
        Load = 1'b0; Enable = 1'b0;
        expectEq("B.reset.Q", 32'(qB), 32'(0));
        expectEq("C.reset.Q", 32'(qC), 32'(0));
        #2;
        mrB = 1'b0; mrC = 1'b0; enB = 1'b1; enC = 1'b1;
        modelB = 0; modelC = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge CLK);
            #1;
            expOvfB = (modelB == 255);
            modelB  = (modelB + 1) % 256;
            expOvfC = (modelC == 5);
            modelC  = (modelC + 1) % 6;
            expectEq("B.Q", 32'(qB), 32'(modelB));
            expectEq("B.Ovf", 32'(ovfB), 32'(expOvfB));
            expectEq("B.TC", 32'(tcB), 32'(modelB == 255));
            expectEq("B.LoadErr", 32'(errB), 32'(0));
            expectEq("C.Q", 32'(qC), 32'(modelC));
            expectEq("C.Ovf", 32'(ovfC), 32'(expOvfC));
            expectEq("C.TC", 32'(tcC), 32'(modelC == 5));
            expectEq("C.LoadErr", 32'(errC), 32'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
